// File: rtl/alu_defs.sv
// alu_defs: opcode constants and sequencer state encoding shared by the
// control unit, the ALU and alu_sequencer.
package alu_defs;

    localparam logic [4:0] OP_ADD = 5'b00101;
    localparam logic [4:0] OP_SUB = 5'b00110;
    localparam logic [4:0] OP_MUL = 5'b10000;
    localparam logic [4:0] OP_DIV = 5'b10001;
    localparam logic [4:0] OP_NOP = 5'b11110;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_RSP_LO = 2'd2,
        ST_RSP_HI = 2'd3
    } seq_state_e;

endpackage

// File: rtl/alu_sequencer.sv
// alu_sequencer: holds one request stable on the combinational ALU for its
// execute window, captures the double-width result and returns it in 1 or 2 beats.
module alu_sequencer
    import alu_defs::*;
#(
    parameter int DATA_W        = 32,
    parameter int OP_W          = 5,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic                clock,
    input  logic                clear_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [OP_W-1:0]     req_op,
    input  logic [DATA_W-1:0]   req_a,
    input  logic [DATA_W-1:0]   req_b,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [OP_W-1:0]     alu_op,
    input  logic [2*DATA_W-1:0] alu_c,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_hi,
    output logic                rsp_err,
    output logic                busy
);

    localparam int CNT_W = $clog2(MULDIV_CYCLES) + 1;

    seq_state_e          state_q, state_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic [2*DATA_W-1:0] z_q, z_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                req_md, op_md, div_zero;

    assign req_md   = req_op == OP_W'(OP_MUL) || req_op == OP_W'(OP_DIV);
    assign op_md    = op_q == OP_W'(OP_MUL) || op_q == OP_W'(OP_DIV);
    assign div_zero = op_q == OP_W'(OP_DIV) && b_q == '0;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_W'(OP_NOP);
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z_q     <= z_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        z_d     = z_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (req_valid) begin
                state_d = ST_EXEC;
                op_d    = req_op;
                a_d     = req_a;
                b_d     = req_b;
                err_d   = 1'b0;
                cnt_d   = req_md ? CNT_W'(MULDIV_CYCLES - 1) : '0;
            end
            ST_EXEC: if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                // Divide by zero never reaches the ALU; the result is forced to 0.
                state_d = ST_RSP_LO;
                z_d     = div_zero ? '0 : alu_c;
                err_d   = div_zero;
            end
            ST_RSP_LO: if (rsp_ready) state_d = op_md ? ST_RSP_HI : ST_IDLE;
            ST_RSP_HI: if (rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = state_q == ST_IDLE;
        busy      = state_q != ST_IDLE;
        rsp_valid = state_q == ST_RSP_LO || state_q == ST_RSP_HI;
        rsp_hi    = state_q == ST_RSP_HI;
        rsp_data  = rsp_hi ? z_q[2*DATA_W-1:DATA_W] : rsp_valid ? z_q[DATA_W-1:0] : '0;
        rsp_err   = err_q;
        alu_a     = state_q == ST_EXEC ? a_q : '0;
        alu_b     = state_q == ST_EXEC ? b_q : '0;
        alu_op    = state_q == ST_EXEC && !div_zero ? op_q : OP_W'(OP_NOP);
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle front-end that sequences the 32-bit ALU for a single requester. It uses a valid/ready request channel and a valid/ready response channel. It latches the operands and opcode, holds them stable on the ALU inputs for the required number of execute cycles, and captures the 64-bit result into an internal Z register. It then returns the result as one 32-bit beat, or two beats (LO then HI) for MUL/DIV. It sits between the control unit/bus and the combinational ALU.

Parameters:
DATA_W, 32, operand and response beat width; result width is 2*DATA_W
OP_W, 5, ALU opcode width
MULDIV_CYCLES, 4, execute cycles allowed for MUL/DIV; must be >= 1

Ports:
clock  in  1  system clock, rising edge
clear_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_op  in  OP_W  ALU opcode
req_a  in  DATA_W  operand A
req_b  in  DATA_W  operand B
alu_a  out  DATA_W  to ALU operand A
alu_b  out  DATA_W  to ALU operand B
alu_op  out  OP_W  to ALU opcode
alu_c  in  2*DATA_W  ALU result
rsp_valid  out  1  response beat present
rsp_ready  in  1  consumer accepts the beat
rsp_data  out  DATA_W  result beat
rsp_hi  out  1  beat is Z[63:32]
rsp_err  out  1  transaction was DIV by zero
busy  out  1  state != IDLE

Behaviour:
- Interface: one clock (clock). Reset clear_n is asynchronous and active-low.
- Reset (asynchronous, any state, including mid-transaction):
  - state=IDLE; Z, operand, opcode and counter registers are cleared.
  - Any in-flight transaction is dropped, with no response.
  - Outputs: req_ready=1, rsp_valid=0, rsp_data=0, rsp_hi=0, rsp_err=0, busy=0, alu_a=alu_b=0, alu_op=NOP (5'b11110).
- States: IDLE, EXEC, RSP_LO, RSP_HI.
- IDLE:
  - req_ready=1.
  - When req_valid&&req_ready: latch req_op/req_a/req_b and go to EXEC.
  - Load cnt = MULDIV_CYCLES-1 for MUL (5'b10000) or DIV (5'b10001); otherwise cnt=0.
- EXEC:
  - req_ready=0.
  - alu_a/alu_b/alu_op are driven from the latched registers; they are NOP/0 in all other states.
  - If cnt!=0, decrement it.
  - If cnt==0, capture Z<=alu_c and go to RSP_LO.
- DIV with latched B==0:
  - Z<=0 and err<=1 at capture; alu_op is still driven NOP for the whole EXEC.
  - err is cleared on acceptance of the next request.
- Unrecognised opcode: ALU default yields 0. Single beat, rsp_err=0.
- RSP_LO:
  - rsp_valid=1, rsp_data=Z[31:0], rsp_hi=0.
  - On rsp_ready: go to RSP_HI if op is MUL/DIV, else IDLE.
- RSP_HI:
  - rsp_valid=1, rsp_data=Z[63:32], rsp_hi=1.
  - On rsp_ready: go to IDLE.
- rsp_err is valid on every beat of the transaction.
- Backpressure: while rsp_valid && !rsp_ready, rsp_data/rsp_hi/rsp_err hold stable. Z never changes outside EXEC capture.
- Latency, with the request handshake at edge 0:
  - Single-cycle ops: rsp_valid at cycle 2.
  - MUL/DIV: LO at cycle 1+MULDIV_CYCLES, HI one cycle after LO is accepted (earliest).
- Throughput: one transaction in flight. req_ready rises only in the cycle after the final beat handshake; there is no same-cycle accept.
- req_valid while busy is ignored. The requester must hold the request until req_ready; there is no deassert protection.
- Width: Z is 2*DATA_W. No arithmetic is done in the sequencer other than the B==0 compare and the counter, which is $clog2(MULDIV_CYCLES)+1 bits.

Decomposition:
- Shared package/header alu_defs: opcode constants (OP_ADD 5'b00101, OP_SUB 5'b00110, OP_MUL 5'b10000, OP_DIV 5'b10001, OP_NOP 5'b11110, …) and state encodings. These are shared with the control unit and ALU.
- The sequencer contains the FSM, operand/Z registers and cnt. It is one module with no sub-module.
- The ALU is instantiated only in the bench/top, not inside alu_sequencer.

Test Plan:
- Reset, then ADD a=5 b=7, rsp_ready=1 -> rsp_valid at cycle 2, data 12, rsp_hi=0, rsp_err=0; busy for 2 cycles; req_ready high again at cycle 3.
- MUL a=0x00010000 b=0x00010000, MULDIV_CYCLES=4 -> alu_op=10000 held for 4 cycles; beat LO=0x00000000 at cycle 5, then HI=0x00000001 with rsp_hi=1; IDLE after.
- DIV a=100 b=0 -> alu_op stays NOP; two beats 0/0 with rsp_err=1; next ADD 1+1 returns 2 with rsp_err=0.
- SUB a=10 b=3 with rsp_ready low for 3 cycles -> rsp_valid held, data 7 stable; req_valid pulses meanwhile are ignored (req_ready=0).
- MUL started, clear_n asserted at cycle 2 of EXEC -> all outputs at reset values immediately; no beat ever emitted; next ADD 2+2 returns 4.
- Opcode 5'b00000 a=9 b=9 -> single beat, data 0, rsp_err=0.
